// File: rtl/lsu_ctrl.sv
// Load/store unit: turns decoded memory ops into single-outstanding bus transactions,
// stalls the pipeline until ack or timeout, and returns extended load data.
module lsu_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [2:0]  mask,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        misalign,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

    function automatic logic access_legal(input logic is_store, input logic [2:0] m,
                                          input logic [1:0] off);
        logic ok;
        case (m)
            3'b000:  ok = 1'b1;
            3'b001:  ok = ~off[0];
            3'b010:  ok = (off == 2'b00);
            3'b100:  ok = ~is_store;
            3'b101:  ok = ~is_store & ~off[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] calc_be(input logic [2:0] m, input logic [1:0] off);
        logic [3:0] be;
        case (m[1:0])
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = 4'b0011 << {off[1], 1'b0};
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] lane_rep(input logic [2:0] m, input logic [31:0] w);
        logic [31:0] r;
        case (m[1:0])
            2'b00:   r = {4{w[7:0]}};
            2'b01:   r = {2{w[15:0]}};
            default: r = w;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] load_ext(input logic [2:0] m, input logic [1:0] off,
                                             input logic [31:0] w);
        logic [31:0] sh;
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        sh = w >> {off, 3'b000};
        b  = sh[7:0];
        h  = off[1] ? w[31:16] : w[15:0];
        case (m)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b010:  r = w;
            3'b100:  r = {24'd0, b};
            3'b101:  r = {16'd0, h};
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    state_e      state_q;
    logic [7:0]  cnt_q;
    logic [2:0]  mask_q;
    logic [1:0]  off_q;
    logic [31:0] rdata_q;
    logic        misalign_q;
    logic        bus_err_q;
    logic        bus_req_q;
    logic        bus_we_q;
    logic [31:0] bus_addr_q;
    logic [3:0]  bus_be_q;
    logic [31:0] bus_wdata_q;

    logic access_s;
    logic legal_s;
    logic stall_s;

    // Decode the incoming request and raise stall for accepted accesses and while waiting
    always_comb begin
        access_s = mem_rd | mem_wr;
        legal_s  = access_legal(mem_wr, mask, addr[1:0]);
        if (state_q == S_REQ) begin
            stall_s = 1'b1;
        end else if (state_q == S_IDLE) begin
            stall_s = access_s & legal_s;
        end else begin
            stall_s = 1'b0;
        end
    end

    // Access FSM with registered bus outputs, fault pulses and load result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 8'd0;
            mask_q      <= 3'd0;
            off_q       <= 2'd0;
            rdata_q     <= 32'd0;
            misalign_q  <= 1'b0;
            bus_err_q   <= 1'b0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'd0;
            bus_be_q    <= 4'd0;
            bus_wdata_q <= 32'd0;
        end else begin
            misalign_q <= 1'b0;
            bus_err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (access_s && legal_s) begin
                        state_q     <= S_REQ;
                        bus_req_q   <= 1'b1;
                        bus_we_q    <= mem_wr;
                        mask_q      <= mask;
                        off_q       <= addr[1:0];
                        bus_addr_q  <= {addr[31:2], 2'b00};
                        bus_be_q    <= calc_be(mask, addr[1:0]);
                        bus_wdata_q <= lane_rep(mask, wdata);
                        cnt_q       <= 8'd0;
                    end else if (access_s) begin
                        misalign_q <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (bus_ack) begin
                        if (!bus_we_q) begin
                            rdata_q <= load_ext(mask_q, off_q, bus_rdata);
                        end
                        bus_req_q <= 1'b0;
                        state_q   <= S_DONE;
                    end else if (cnt_q == TO_LAST) begin
                        // Timed-out loads return zero so the core never sees stale data
                        if (!bus_we_q) begin
                            rdata_q <= 32'd0;
                        end
                        bus_err_q <= 1'b1;
                        bus_req_q <= 1'b0;
                        state_q   <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q   <= S_IDLE;
                    bus_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign stall     = stall_s;
    assign rdata     = rdata_q;
    assign misalign  = misalign_q;
    assign bus_err   = bus_err_q;
    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_be    = bus_be_q;
    assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: vector table of single accesses plus hand-written
// timeout, late-ack and reset-mid-operation sequences.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_rd, mem_wr;
    logic [2:0]  mask;
    logic [31:0] addr, wdata;
    logic [31:0] rdata;
    logic        stall, misalign, bus_err, bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    int n_cmp = 0;
    int n_err = 0;

    lsu_ctrl #(.TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst_n(rst_n), .mem_rd(mem_rd), .mem_wr(mem_wr), .mask(mask),
        .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall), .misalign(misalign),
        .bus_err(bus_err), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  m;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] brd;
        int          waits;
        logic        fault;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic        e_we;
        logic [31:0] e_wdata;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t vecs[14];

    function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] m,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] brd, input int waits, input logic fault,
                                input logic [31:0] e_addr, input logic [3:0] e_be,
                                input logic e_we, input logic [31:0] e_wdata,
                                input logic [31:0] e_rdata);
        vec_t v;
        v.rd = rd; v.wr = wr; v.m = m; v.a = a; v.wd = wd; v.brd = brd;
        v.waits = waits; v.fault = fault; v.e_addr = e_addr; v.e_be = e_be;
        v.e_we = e_we; v.e_wdata = e_wdata; v.e_rdata = e_rdata;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        mem_rd = 1'b0;
        mem_wr = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int stall_cnt;
        @(posedge clk); #1;
        mem_rd = v.rd; mem_wr = v.wr; mask = v.m; addr = v.a; wdata = v.wd;
        #1;
        chk("idle_stall", {31'd0, stall}, {31'd0, ~v.fault});
        chk("idle_req", {31'd0, bus_req}, 32'd0);
        stall_cnt = stall ? 1 : 0;
        @(posedge clk); #1;
        if (v.fault) begin
            chk("fault_misalign", {31'd0, misalign}, 32'd1);
            chk("fault_req", {31'd0, bus_req}, 32'd0);
            chk("fault_stall", {31'd0, stall}, 32'd0);
            chk("fault_rdata", rdata, v.e_rdata);
            idle_inputs();
            @(posedge clk); #1;
            chk("misalign_pulse_end", {31'd0, misalign}, 32'd0);
        end else begin
            for (int c = 0; c <= v.waits; c++) begin
                chk("req_high", {31'd0, bus_req}, 32'd1);
                chk("req_addr", bus_addr, v.e_addr);
                chk("req_be", {28'd0, bus_be}, {28'd0, v.e_be});
                chk("req_we", {31'd0, bus_we}, {31'd0, v.e_we});
                chk("req_wdata", bus_wdata, v.e_wdata);
                if (stall) stall_cnt++;
                if (c == v.waits) begin
                    bus_ack = 1'b1;
                    bus_rdata = v.brd;
                end
                @(posedge clk); #1;
                bus_ack = 1'b0;
                bus_rdata = 32'h5A5A_5A5A;
            end
            chk("done_stall", {31'd0, stall}, 32'd0);
            chk("done_req", {31'd0, bus_req}, 32'd0);
            chk("done_rdata", rdata, v.e_rdata);
            chk("done_err", {31'd0, bus_err}, 32'd0);
            chk("stall_cycles", stall_cnt, v.waits + 2);
            idle_inputs();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        vecs[0]  = mk(1, 0, 3'b000, 32'h1003, 0, 32'h80AA_BBCC, 0, 0, 32'h1000, 4'b1000, 0, 0, 32'hFFFF_FF80);
        vecs[1]  = mk(0, 1, 3'b001, 32'h2002, 32'h1234_ABCD, 0, 0, 0, 32'h2000, 4'b1100, 1, 32'hABCD_ABCD, 32'hFFFF_FF80);
        vecs[2]  = mk(1, 0, 3'b101, 32'h0, 0, 32'h0000_F00D, 3, 0, 32'h0, 4'b0011, 0, 0, 32'h0000_F00D);
        vecs[3]  = mk(1, 0, 3'b010, 32'h6, 0, 0, 0, 1, 0, 0, 0, 0, 32'h0000_F00D);
        vecs[4]  = mk(0, 1, 3'b100, 32'h10, 0, 0, 0, 1, 0, 0, 0, 0, 32'h0000_F00D);
        vecs[5]  = mk(1, 0, 3'b001, 32'h2, 0, 32'h8001_1234, 1, 0, 32'h0, 4'b1100, 0, 0, 32'hFFFF_8001);
        vecs[6]  = mk(1, 0, 3'b100, 32'h1, 0, 32'h0000_1280, 2, 0, 32'h0, 4'b0010, 0, 0, 32'h0000_0012);
        vecs[7]  = mk(1, 0, 3'b010, 32'h100, 0, 32'hDEAD_BEEF, 0, 0, 32'h100, 4'b1111, 0, 0, 32'hDEAD_BEEF);
        vecs[8]  = mk(0, 1, 3'b000, 32'h3001, 32'h0000_00A5, 0, 1, 0, 32'h3000, 4'b0010, 1, 32'hA5A5_A5A5, 32'hDEAD_BEEF);
        vecs[9]  = mk(0, 1, 3'b010, 32'h40, 32'hCAFE_F00D, 0, 0, 0, 32'h40, 4'b1111, 1, 32'hCAFE_F00D, 32'hDEAD_BEEF);
        vecs[10] = mk(1, 1, 3'b010, 32'h44, 32'h1122_3344, 0, 0, 0, 32'h44, 4'b1111, 1, 32'h1122_3344, 32'hDEAD_BEEF);
        vecs[11] = mk(1, 0, 3'b001, 32'h1, 0, 0, 0, 1, 0, 0, 0, 0, 32'hDEAD_BEEF);
        vecs[12] = mk(1, 0, 3'b011, 32'h0, 0, 0, 0, 1, 0, 0, 0, 0, 32'hDEAD_BEEF);
        vecs[13] = mk(1, 0, 3'b000, 32'h2, 0, 32'h007F_0000, 0, 0, 32'h0, 4'b0100, 0, 0, 32'h0000_007F);

        rst_n = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0; mask = 3'b000; addr = 32'd0;
        wdata = 32'd0; bus_ack = 1'b0; bus_rdata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req", {31'd0, bus_req}, 32'd0);
        chk("rst_we", {31'd0, bus_we}, 32'd0);
        chk("rst_addr", bus_addr, 32'd0);
        chk("rst_be", {28'd0, bus_be}, 32'd0);
        chk("rst_wdata", bus_wdata, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_misalign", {31'd0, misalign}, 32'd0);
        chk("rst_err", {31'd0, bus_err}, 32'd0);
        chk("rst_stall_idle", {31'd0, stall}, 32'd0);
        mem_rd = 1'b1; mask = 3'b010;
        #1;
        chk("rst_stall_follows", {31'd0, stall}, 32'd1);
        mem_rd = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            run_vec(vecs[i]);
        end

        // Timeout: load never acknowledged
        @(posedge clk); #1;
        mem_rd = 1'b1; mask = 3'b010; addr = 32'h8;
        @(posedge clk); #1;
        cnt = 0;
        while (bus_req && cnt < 40) begin
            cnt++;
            @(posedge clk); #1;
        end
        chk("to_req_cycles", cnt, 16);
        chk("to_err", {31'd0, bus_err}, 32'd1);
        chk("to_rdata", rdata, 32'd0);
        chk("to_stall", {31'd0, stall}, 32'd0);
        idle_inputs();
        @(posedge clk); #1;
        chk("to_err_pulse_end", {31'd0, bus_err}, 32'd0);
        bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        bus_ack = 1'b0;
        @(posedge clk); #1;
        chk("late_ack_req", {31'd0, bus_req}, 32'd0);
        chk("late_ack_rdata", rdata, 32'd0);
        chk("late_ack_stall", {31'd0, stall}, 32'd0);

        // Reset while a load is outstanding
        run_vec(vecs[7]);
        @(posedge clk); #1;
        mem_rd = 1'b1; mask = 3'b010; addr = 32'h20;
        @(posedge clk); #1;
        chk("mid_req_before", {31'd0, bus_req}, 32'd1);
        mem_rd = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req", {31'd0, bus_req}, 32'd0);
        chk("mid_rst_addr", bus_addr, 32'd0);
        chk("mid_rst_be", {28'd0, bus_be}, 32'd0);
        chk("mid_rst_rdata", rdata, 32'd0);
        chk("mid_rst_stall", {31'd0, stall}, 32'd0);
        bus_ack = 1'b1; bus_rdata = 32'h1234_5678;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        bus_ack = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_req", {31'd0, bus_req}, 32'd0);
        chk("post_rst_rdata", rdata, 32'd0);
        chk("post_rst_err", {31'd0, bus_err}, 32'd0);
        run_vec(vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
